// File: rtl/sobel_edge_pkg.sv
// Shared constants for the Sobel edge streaming pipeline.
package sobel_edge_pkg;

  localparam logic MODE_MAG = 1'b0;  // saturated gradient magnitude
  localparam logic MODE_BIN = 1'b1;  // binary edge map against a threshold

  // Clock edges from the edge that samples a triggering beat to the edge
  // that presents its result on dout.
  localparam int LAT = 2;

  // |Gx|+|Gy| peaks at 8*(2^DATA_W-1), which needs three extra bits.
  function automatic int mag_w(input int data_w);
    return data_w + 3;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// One line of pixel history: write and read share the column address, so a
// read returns the pixel stored one line earlier at that column.
module sobel_line_buf
  import sobel_edge_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int AW     = (IMG_W > 1) ? $clog2(IMG_W) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [IMG_W];

  // Store the incoming pixel at its column.
  // NOTE: the RAM has no reset on purpose -- its contents are always
  // overwritten before they can reach an output, and a reset would prevent
  // mapping onto RAM primitives. State updates use <= so every register in
  // the design sees pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read-before-write view of the same column for the cascade and window.
  assign rdata = mem[addr];

endmodule

// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector over raster-order gray pixels.
module sobel_edge_stream
  import sobel_edge_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [DATA_W-1:0] thresh,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  input  logic              din_sop,
  input  logic              din_eop,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  output logic              dout_sop,
  output logic              dout_eop
);

  localparam int MW = mag_w(DATA_W);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [DATA_W-1:0] PIX_MAX = '1;

  logic              in_frame;
  logic [CW-1:0]     col_q, pos_c;
  logic [RW-1:0]     row_q, pos_r;
  logic              accept, kill, at_last;
  logic              mode_q;
  logic [DATA_W-1:0] thresh_q;
  logic [DATA_W-1:0] lb0_rd, lb1_rd;
  logic [DATA_W-1:0] win [3][3];  // [row: 0=oldest line][col: 2=newest]
  logic              win_vld, win_sop, win_eop;
  logic [MW-1:0]     gx, gy, abs_gx, abs_gy, mag_c, mag_q;
  logic              mag_vld, mag_sop, mag_eop;
  logic [DATA_W-1:0] dout_c;

  function automatic logic [MW-1:0] tap_sum(input logic [DATA_W-1:0] a,
                                            input logic [DATA_W-1:0] b,
                                            input logic [DATA_W-1:0] c);
    return MW'(a) + (MW'(b) << 1) + MW'(c);
  endfunction

  // Decode the position of this beat; a sop restarts the frame at (0,0)
  // and flushes anything still in flight from the aborted frame.
  // NOTE: every always_comb output is assigned on all paths, so no latch forms.
  always_comb begin
    kill    = din_vld && din_sop;
    accept  = din_vld && (din_sop || in_frame);
    pos_c   = din_sop ? '0 : col_q;
    pos_r   = din_sop ? '0 : row_q;
    at_last = (pos_r == RW'(IMG_H - 1)) && (pos_c == CW'(IMG_W - 1));
  end

  // Raster counters, frame-active flag and per-frame mode/threshold capture.
  // A beat flagged din_eop also closes the frame, like the last position.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_frame <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      mode_q   <= MODE_MAG;
      thresh_q <= '0;
    end else if (accept) begin
      if (kill) begin
        mode_q   <= mode;
        thresh_q <= thresh;
      end
      in_frame <= !(at_last || din_eop);
      if (pos_c == CW'(IMG_W - 1)) begin
        col_q <= '0;
        row_q <= pos_r + 1'b1;
      end else begin
        col_q <= pos_c + 1'b1;
        row_q <= pos_r;
      end
    end
  end

  sobel_line_buf #(.DATA_W(DATA_W), .IMG_W(IMG_W), .AW(CW)) u_lb_r1 (
    .clk   (clk),
    .we    (accept),
    .addr  (pos_c),
    .wdata (din),
    .rdata (lb0_rd)
  );

  sobel_line_buf #(.DATA_W(DATA_W), .IMG_W(IMG_W), .AW(CW)) u_lb_r2 (
    .clk   (clk),
    .we    (accept),
    .addr  (pos_c),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  // Shift a new column into the 3x3 window; the centre lands on (r-1,c-1).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++) win[i][j] <= '0;
      win_vld <= 1'b0;
      win_sop <= 1'b0;
      win_eop <= 1'b0;
    end else begin
      win_vld <= accept && (pos_r >= RW'(2)) && (pos_c >= CW'(2));
      win_sop <= accept && (pos_r == RW'(2)) && (pos_c == CW'(2));
      win_eop <= accept && at_last;
      if (accept) begin
        for (int i = 0; i < 3; i++) begin
          win[i][0] <= win[i][1];
          win[i][1] <= win[i][2];
        end
        win[0][2] <= lb1_rd;
        win[1][2] <= lb0_rd;
        win[2][2] <= din;
      end
    end
  end

  // Sobel gradients and L1 magnitude of the current window.
  always_comb begin
    gx     = tap_sum(win[0][2], win[1][2], win[2][2])
           - tap_sum(win[0][0], win[1][0], win[2][0]);
    gy     = tap_sum(win[2][0], win[2][1], win[2][2])
           - tap_sum(win[0][0], win[0][1], win[0][2]);
    abs_gx = gx[MW-1] ? -gx : gx;
    abs_gy = gy[MW-1] ? -gy : gy;
    mag_c  = abs_gx + abs_gy;
  end

  // Register the magnitude; a sop drops the older beat travelling here.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_vld <= 1'b0;
      mag_sop <= 1'b0;
      mag_eop <= 1'b0;
      mag_q   <= '0;
    end else begin
      mag_vld <= win_vld && !kill;
      mag_sop <= win_sop;
      mag_eop <= win_eop;
      if (win_vld) mag_q <= mag_c;
    end
  end

  // Map magnitude to a pixel with the mode captured at frame start.
  always_comb begin
    dout_c = '0;
    if (mode_q == MODE_BIN) begin
      if (mag_q >= MW'(thresh_q)) dout_c = PIX_MAX;
    end else if (mag_q > MW'(PIX_MAX)) begin
      dout_c = PIX_MAX;
    end else begin
      dout_c = mag_q[DATA_W-1:0];
    end
  end

  // Output register; dout holds its value between valid beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout     <= '0;
      dout_vld <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
    end else begin
      dout_vld <= mag_vld && !kill;
      dout_sop <= mag_vld && !kill && mag_sop;
      dout_eop <= mag_vld && !kill && mag_eop;
      if (mag_vld && !kill) dout <= dout_c;
    end
  end

endmodule

// File: tb/tb_sobel_edge_stream.sv
// Scoreboard bench for sobel_edge_stream on an 8x6 frame.
module tb_sobel_edge_stream;

  localparam int DW      = 8;
  localparam int W       = 8;
  localparam int H       = 6;
  localparam int EXP_LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          mode;
  logic [DW-1:0] thresh, din, dout;
  logic          din_vld, din_sop, din_eop;
  logic          dout_vld, dout_sop, dout_eop;

  typedef enum int {K_FLAT, K_VSTEP, K_HSTEP, K_RAMP, K_RAMPX} kind_e;
  typedef struct {
    logic [DW-1:0] data;
    bit            sop;
    bit            eop;
    int            at_cyc;
  } exp_t;

  exp_t          sb[$];
  int            cyc = 0;
  int            n_vec = 0;
  int            n_miss = 0;
  logic [DW-1:0] last_exp = '0;
  kind_e         cur_kind = K_FLAT;
  logic          cur_mode = 1'b0;
  logic [DW-1:0] cur_thr = '0;

  sobel_edge_stream #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .thresh   (thresh),
    .din      (din),
    .din_vld  (din_vld),
    .din_sop  (din_sop),
    .din_eop  (din_eop),
    .dout     (dout),
    .dout_vld (dout_vld),
    .dout_sop (dout_sop),
    .dout_eop (dout_eop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] pix(input kind_e k, input int r, input int c);
    int v;
    case (k)
      K_FLAT:  v = 100;
      K_VSTEP: v = (c < 4) ? 0 : 200;
      K_HSTEP: v = (r < 3) ? 0 : 200;
      K_RAMP:  v = 100 - 10 * c + 5 * r;
      default: v = 10 * c;
    endcase
    return DW'(v);
  endfunction

  // Hand-derived |Gx|+|Gy| per image kind for centre (cr,cc).
  function automatic logic [DW-1:0] expect_px(input kind_e k, input logic md,
                                              input logic [DW-1:0] th,
                                              input int cr, input int cc);
    int mag;
    case (k)
      K_FLAT:  mag = 0;
      K_VSTEP: mag = (cc == 3 || cc == 4) ? 800 : 0;
      K_HSTEP: mag = (cr == 2 || cr == 3) ? 800 : 0;
      K_RAMP:  mag = 120;
      default: mag = 80;
    endcase
    if (md) return (mag >= int'(th)) ? 8'hFF : 8'h00;
    return (mag > 255) ? 8'hFF : DW'(mag);
  endfunction

  // Drop expectations due at or after clock edge lim.
  function automatic void purge(input int lim);
    exp_t keep[$];
    foreach (sb[i]) if (sb[i].at_cyc < lim) keep.push_back(sb[i]);
    sb = keep;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      din_vld = 1'b0;
      din_sop = 1'b0;
      din_eop = 1'b0;
    end
  endtask

  task automatic drive_beat(input logic [DW-1:0] px, input bit sop, input int r,
                            input int c, input bit push);
    exp_t e;
    @(negedge clk);
    din     = px;
    din_vld = 1'b1;
    din_sop = sop;
    din_eop = (r == H - 1) && (c == W - 1);
    if (sop) purge(cyc + 1);
    if (push && r >= 2 && c >= 2) begin
      e.data   = expect_px(cur_kind, cur_mode, cur_thr, r - 1, c - 1);
      e.sop    = (r == 2) && (c == 2);
      e.eop    = (r == H - 1) && (c == W - 1);
      e.at_cyc = cyc + 1 + EXP_LAT;
      sb.push_back(e);
    end
  endtask

  // Beats first..last-1 of a frame; beat 0 carries sop and fixes mode/thresh.
  task automatic run_frame(input kind_e k, input logic md, input logic [DW-1:0] th,
                           input int max_gap, input int first, input int last,
                           input int thr_mid, input bit push);
    for (int i = first; i < last; i++) begin
      if (i == 0) begin
        mode     = md;
        thresh   = th;
        cur_kind = k;
        cur_mode = md;
        cur_thr  = th;
      end
      if (i == thr_mid) thresh = 8'h00;
      drive_beat(pix(k, i / W, i % W), i == 0, i / W, i % W, push);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  // Monitor: every output cycle pops one expectation; idle cycles check hold.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (dout_vld) begin
        if (sb.size() == 0) begin
          check("unexpected_dout_vld", 32'(dout_vld), 32'd0);
        end else begin
          e = sb.pop_front();
          check("dout", 32'(dout), 32'(e.data));
          check("dout_sop", 32'(dout_sop), 32'(e.sop));
          check("dout_eop", 32'(dout_eop), 32'(e.eop));
          check("dout_latency_cycle", 32'(cyc), 32'(e.at_cyc));
          last_exp = e.data;
        end
      end else begin
        check("dout_hold", 32'(dout), 32'(last_exp));
        check("sop_eop_without_vld", 32'({dout_sop, dout_eop}), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mode = 1'b0; thresh = '0; din = '0;
    din_vld = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_dout", 32'(dout), 32'd0);
    check("reset_flags", 32'({dout_vld, dout_sop, dout_eop}), 32'd0);
    rst = 1'b0;
    idle(2);

    run_frame(K_FLAT,  1'b0, 8'd0,  0, 0, W*H, -1, 1'b1); idle(4);
    run_frame(K_VSTEP, 1'b0, 8'd0,  0, 0, W*H, -1, 1'b1); idle(4);
    run_frame(K_VSTEP, 1'b1, 8'd50, 0, 0, W*H, 24, 1'b1); idle(4);
    run_frame(K_HSTEP, 1'b0, 8'd0,  0, 0, W*H, -1, 1'b1); idle(4);
    run_frame(K_RAMP,  1'b0, 8'd0,  0, 0, W*H, -1, 1'b1); idle(4);
    run_frame(K_RAMPX, 1'b1, 8'd80, 0, 0, W*H, -1, 1'b1); idle(4);
    run_frame(K_RAMPX, 1'b1, 8'd81, 0, 0, W*H, -1, 1'b1); idle(4);
    // Random gaps: same results, each output still two edges after its beat.
    run_frame(K_VSTEP, 1'b0, 8'd0,  3, 0, W*H, -1, 1'b1); idle(4);

    // Abort after 20 beats; new sop arrives on the very next cycle.
    run_frame(K_RAMPX, 1'b1, 8'd0,  0, 0, 20,  -1, 1'b1);
    run_frame(K_VSTEP, 1'b0, 8'd0,  0, 0, W*H, -1, 1'b1); idle(4);

    // Reset in place of beat 30, then the rest of the frame without sop.
    run_frame(K_HSTEP, 1'b0, 8'd0,  0, 0, 30,  -1, 1'b1);
    @(negedge clk);
    rst = 1'b1; din = pix(K_HSTEP, 3, 6); din_vld = 1'b1; din_sop = 1'b0; din_eop = 1'b0;
    purge(cyc + 1);
    last_exp = '0;
    @(negedge clk);
    rst = 1'b0; din_vld = 1'b0;
    check("midframe_reset_dout", 32'(dout), 32'd0);
    check("midframe_reset_flags", 32'({dout_vld, dout_sop, dout_eop}), 32'd0);
    run_frame(K_HSTEP, 1'b0, 8'd0,  0, 31, W*H, -1, 1'b0); idle(4);
    run_frame(K_RAMP,  1'b0, 8'd0,  0, 0, W*H, -1, 1'b1); idle(6);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
